ah_pad: RTL
===========

// Module: ah_pad
// PURPOSE
//  MD5 message padder and block feeder on the write side of the hash core's word shift register.
//  - Accepts the message as a stream of 32-bit little-endian words with valid/ready.
//  - Emits 16-word blocks on DataVld/DataOut, word 0 first.
//  - Appends 0x80, the zero fill and the 64-bit bit-length (low word at index 14, high at 15).
//  - Pulses BlockDone on the 16th word so the round engine can start.
// PARAMETERS
//  DATA_WIDTH   32  word width (fixed for MD5; from ah_params.vh)
//  LEN_WIDTH    64  message bit-length field width
//  BLK_WORDS    16  words per block
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  MsgVld     in   1   message word valid
//  MsgRdy     out  1   padder accepts word (transfer = MsgVld & MsgRdy)
//  MsgData    in   32  message word; byte k at bits [8k+7:8k]
//  MsgLast    in   1   final word of message
//  MsgBytes   in   3   valid bytes in word, 0..4; must be 4 unless MsgLast
//  CoreRdy    in   1   core idle, may take a new block
//  DataVld    out  1   DataOut valid, one word to shift register
//  DataOut    out  32  block word
//  BlockDone  out  1   pulse with 16th DataVld of each block
//  MsgDone    out  1   pulse with 16th word of the final block
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; word index 0; byte count 0.
//  FSM states: IDLE, WAIT_CORE, DATA, PAD, LEN_LO, LEN_HI.
//  - IDLE -> WAIT_CORE on MsgVld.
//  - WAIT_CORE: CoreRdy is sampled only here, before word 0 of every block.
//    - Blocks are never stalled by CoreRdy once started.
//    - On CoreRdy=1, go to DATA; if the message is already done, go to PAD.
//  - DATA: MsgRdy=1.
//    - Each transfer drives DataVld=1 next cycle with DataOut=MsgData.
//    - Bytes >= MsgBytes are zeroed; byte MsgBytes is set to 0x80 when MsgLast & MsgBytes<4.
//    - Byte counter += MsgBytes (LEN_WIDTH-3 bits, wraps silently).
//  - Last word with MsgBytes=4, or MsgBytes=0: 0x80 goes at byte 0 of the next emitted word.
//    - MsgBytes=0 is legal only with MsgLast; that word's data is discarded.
//  - Gaps: DataVld low while MsgVld is low; block word index holds. The core tolerates gaps.
//  - PAD: emits 0x80 word (if still owed), then 0x00000000, one per cycle, MsgRdy=0.
//    - Once the 0x80 is placed and index=14 is next: go to LEN_LO.
//    - If the 0x80 landed at index 14 or 15: zero-fill to index 15, BlockDone, WAIT_CORE.
//      The next block is zeros 0..13, then the length.
//  - LEN_LO: DataOut = bitcount[31:0] (bytes<<3).
//  - LEN_HI: DataOut = bitcount[63:32]; BlockDone=MsgDone=1; counters cleared; go to IDLE.
//  - Word index 15 in DATA/PAD: BlockDone=1, index wraps to 0, go to WAIT_CORE.
//  - Latency: message word to DataOut is 1 cycle; outputs are registered.
//  - MsgVld during LEN_*/WAIT_CORE: held off (MsgRdy=0). A new message starts only from IDLE.
//  - Async reset mid-block aborts; the core discards the partial block (its state also resets).
// CONFIGURATION
//  AH_PAD_ERR_EN defined: adds output PadErr (1 bit, reset 0, sticky until rst_n).
//  - Sets on a transfer with MsgBytes!=4 & !MsgLast.
//  - Sets on MsgBytes>4.
//  - Sets on byte-counter overflow.
//  - The offending word is still processed as if MsgBytes=4.
//  AH_PAD_ERR_EN undefined: no PadErr port, no checks; behaviour otherwise identical.
// STRUCTURE
//  ah_params.vh: DATA_WIDTH, LEN_WIDTH, BLK_WORDS, FSM state encodings, PAD_BYTE=8'h80.
//  Sub-module ah_pad_mask: combinational byte mask/0x80 insert (MsgData, MsgBytes, MsgLast).
//  Control FSM, word index and byte counter live in ah_pad.
// TESTING
//  - Empty msg (MsgBytes=0, MsgLast):
//    one block; w0=0x00000080, w1..w15=0; BlockDone+MsgDone on w15.
//  - "abc" (MsgData=0x00636261, MsgBytes=3, MsgLast):
//    w0=0x80636261, w14=0x00000018, w15=0.
//  - 55 bytes: single block, w13 byte3=0x80, w14=0x000001B8.
//    56 bytes: two blocks, 2nd w14=0x000001C0, 1st w14=0x00000080.
//  - 64 bytes (16 full words):
//    2nd block w0=0x00000080, w14=0x00000200; exactly two BlockDone, one MsgDone.
//  - CoreRdy=0 held 20 cycles at block boundary: no DataVld, MsgRdy=0; resumes 1 cycle after CoreRdy=1.
//    MsgVld gaps mid-block: words still contiguous in index.
//  - rst_n low at word 7: DataVld/BlockDone/MsgRdy drop immediately.
//    Next message restarts at w0 with length counted from 0.
//    With AH_PAD_ERR_EN, a MsgBytes=2 non-last word sets PadErr.

Source files
------------

// File: rtl/ah_pad_pkg.sv
// Shared constants, FSM encoding and MsgBytes sanitising helpers for the MD5 padder.
package ah_pad_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int LEN_WIDTH  = 64;
    localparam int BLK_WORDS  = 16;
    localparam int CNT_WIDTH  = LEN_WIDTH - 3;
    localparam int IDX_WIDTH  = 4;

    localparam logic [7:0]           PAD_BYTE     = 8'h80;
    localparam logic [IDX_WIDTH-1:0] IDX_LAST     = 4'(BLK_WORDS - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_PRE_LEN  = 4'(BLK_WORDS - 3);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_CORE = 3'd1,
        ST_DATA      = 3'd2,
        ST_PAD       = 3'd3,
        ST_LEN_LO    = 3'd4,
        ST_LEN_HI    = 3'd5
    } padState_t;

    // A word is malformed when it claims more than four bytes, or is short without being last.
    function automatic logic bytesBad(input logic [2:0] bytes, input logic last);
        return (bytes > 3'd4) || ((bytes != 3'd4) && !last);
    endfunction

    function automatic logic [2:0] bytesEff(input logic [2:0] bytes, input logic last);
        return bytesBad(bytes, last) ? 3'd4 : bytes;
    endfunction

endpackage

// File: rtl/ah_pad_mask.sv
// Combinational byte mask: keeps valid message bytes, zeroes the rest and inserts 0x80 after a short last word.
module ah_pad_mask
    import ah_pad_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] wordIn,
    input  logic [2:0]            bytes,
    input  logic                  last,
    output logic [DATA_WIDTH-1:0] wordOut
);

    // Per-byte select between message data, pad marker and zero fill.
    always_comb begin
        wordOut = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < bytes) begin
                wordOut[8*k +: 8] = wordIn[8*k +: 8];
            end else if (last && (3'(k) == bytes)) begin
                wordOut[8*k +: 8] = PAD_BYTE;
            end else begin
                wordOut[8*k +: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/ah_pad.sv
// MD5 message padder / block feeder. Optional build macro AH_PAD_ERR_EN adds the sticky PadErr output.
module ah_pad
    import ah_pad_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MsgVld,
    output logic        MsgRdy,
    input  logic [31:0] MsgData,
    input  logic        MsgLast,
    input  logic [2:0]  MsgBytes,
    input  logic        CoreRdy,
    output logic        DataVld,
    output logic [31:0] DataOut,
    output logic        BlockDone,
    output logic        MsgDone
`ifdef AH_PAD_ERR_EN
    ,
    output logic        PadErr
`endif
);

    padState_t              state_r, stateNext_s;
    logic [IDX_WIDTH-1:0]   wordIdx_r, wordIdxNext_s;
    logic [CNT_WIDTH-1:0]   byteCnt_r, byteCntNext_s, cntSumLo_s;
    logic                   padOwed_r, padOwedNext_s;
    logic                   msgEnd_r, msgEndNext_s;
    logic                   dataVldNext_s, blockDoneNext_s, msgDoneNext_s;
    logic [DATA_WIDTH-1:0]  dataOutNext_s, maskedWord_s;
    logic [LEN_WIDTH-1:0]   bitCnt_s;
    logic [2:0]             effBytes_s;
    logic                   xfer_s, lastOwes_s;

    // Malformed byte counts are treated as full words so the stream stays word-aligned.
    assign effBytes_s = bytesEff(MsgBytes, MsgLast);
    assign xfer_s     = MsgVld & MsgRdy;
    assign lastOwes_s = (effBytes_s == 3'd4) || (effBytes_s == 3'd0);
    assign bitCnt_s   = {byteCnt_r, 3'b000};

`ifdef AH_PAD_ERR_EN
    logic [CNT_WIDTH:0] cntSum_s;
    logic               cntOvf_s;
    assign cntSum_s   = {1'b0, byteCnt_r} + {{(CNT_WIDTH-2){1'b0}}, effBytes_s};
    assign cntSumLo_s = cntSum_s[CNT_WIDTH-1:0];
    assign cntOvf_s   = cntSum_s[CNT_WIDTH];
`else
    assign cntSumLo_s = byteCnt_r + {{(CNT_WIDTH-3){1'b0}}, effBytes_s};
`endif

    ah_pad_mask uMask (
        .wordIn  (MsgData),
        .bytes   (effBytes_s),
        .last    (MsgLast),
        .wordOut (maskedWord_s)
    );

    // Next-state and next-output logic for the block feeder.
    always_comb begin
        stateNext_s     = state_r;
        wordIdxNext_s   = wordIdx_r;
        byteCntNext_s   = byteCnt_r;
        padOwedNext_s   = padOwed_r;
        msgEndNext_s    = msgEnd_r;
        dataVldNext_s   = 1'b0;
        dataOutNext_s   = 32'h0000_0000;
        blockDoneNext_s = 1'b0;
        msgDoneNext_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (MsgVld) begin
                    stateNext_s = ST_WAIT_CORE;
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_WAIT_CORE: begin
                if (CoreRdy) begin
                    stateNext_s = msgEnd_r ? ST_PAD : ST_DATA;
                end else begin
                    stateNext_s = ST_WAIT_CORE;
                end
            end
            ST_DATA: begin
                if (xfer_s) begin
                    byteCntNext_s = cntSumLo_s;
                    if (MsgLast) begin
                        msgEndNext_s  = 1'b1;
                        padOwedNext_s = lastOwes_s;
                    end else begin
                        msgEndNext_s  = msgEnd_r;
                    end
                    // An empty last word carries no data: the marker goes out from PAD instead.
                    if (effBytes_s == 3'd0) begin
                        stateNext_s = ST_PAD;
                    end else begin
                        dataVldNext_s = 1'b1;
                        dataOutNext_s = maskedWord_s;
                        if (wordIdx_r == IDX_LAST) begin
                            blockDoneNext_s = 1'b1;
                            wordIdxNext_s   = 4'd0;
                            stateNext_s     = ST_WAIT_CORE;
                        end else begin
                            wordIdxNext_s = wordIdx_r + 4'd1;
                            if (!MsgLast) begin
                                stateNext_s = ST_DATA;
                            end else if (!lastOwes_s && (wordIdx_r == IDX_PRE_LEN)) begin
                                stateNext_s = ST_LEN_LO;
                            end else begin
                                stateNext_s = ST_PAD;
                            end
                        end
                    end
                end else begin
                    stateNext_s = ST_DATA;
                end
            end
            ST_PAD: begin
                dataVldNext_s = 1'b1;
                dataOutNext_s = padOwed_r ? {24'h00_0000, PAD_BYTE} : 32'h0000_0000;
                padOwedNext_s = 1'b0;
                if (wordIdx_r == IDX_LAST) begin
                    blockDoneNext_s = 1'b1;
                    wordIdxNext_s   = 4'd0;
                    stateNext_s     = ST_WAIT_CORE;
                end else begin
                    wordIdxNext_s = wordIdx_r + 4'd1;
                    stateNext_s   = (wordIdx_r == IDX_PRE_LEN) ? ST_LEN_LO : ST_PAD;
                end
            end
            ST_LEN_LO: begin
                dataVldNext_s = 1'b1;
                dataOutNext_s = bitCnt_s[31:0];
                wordIdxNext_s = wordIdx_r + 4'd1;
                stateNext_s   = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                dataVldNext_s   = 1'b1;
                dataOutNext_s   = bitCnt_s[63:32];
                blockDoneNext_s = 1'b1;
                msgDoneNext_s   = 1'b1;
                wordIdxNext_s   = 4'd0;
                byteCntNext_s   = {CNT_WIDTH{1'b0}};
                padOwedNext_s   = 1'b0;
                msgEndNext_s    = 1'b0;
                stateNext_s     = ST_IDLE;
            end
            default: begin
                stateNext_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            wordIdx_r <= 4'd0;
            byteCnt_r <= {CNT_WIDTH{1'b0}};
            padOwed_r <= 1'b0;
            msgEnd_r  <= 1'b0;
            MsgRdy    <= 1'b0;
            DataVld   <= 1'b0;
            DataOut   <= 32'h0000_0000;
            BlockDone <= 1'b0;
            MsgDone   <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            wordIdx_r <= wordIdxNext_s;
            byteCnt_r <= byteCntNext_s;
            padOwed_r <= padOwedNext_s;
            msgEnd_r  <= msgEndNext_s;
            MsgRdy    <= (stateNext_s == ST_DATA);
            DataVld   <= dataVldNext_s;
            DataOut   <= dataOutNext_s;
            BlockDone <= blockDoneNext_s;
            MsgDone   <= msgDoneNext_s;
        end
    end

`ifdef AH_PAD_ERR_EN
    // Sticky error flag: malformed byte count or length counter overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PadErr <= 1'b0;
        end else if (xfer_s && (bytesBad(MsgBytes, MsgLast) || cntOvf_s)) begin
            PadErr <= 1'b1;
        end else begin
            PadErr <= PadErr;
        end
    end
`endif

endmodule
